exception_ctrl: RTL

Exception control stage directly downstream of the main decoder. It consumes Exc/EStatus/ERet, latches the exception link and syndrome registers, and redirects the PC to the handler vector or back to ELR. It also gates the external interrupt line that feeds the decoder's ExtIRQ input, masking it while a handler runs. The system registers are exposed for MRS readout.

---
 rtl/exc_pkg.sv | 25 ++
 rtl/exception_ctrl_if.sv | 31 +++
 rtl/exc_sat_counter.sv | 25 ++
 rtl/exception_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception control stage.
package exc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    FAULT   = 2'd2
  } exc_state_e;

  localparam logic [3:0] ESR_IRQ      = 4'b0001;
  localparam logic [3:0] ESR_NOTINSTR = 4'b0010;
  localparam logic [3:0] ESR_BADERET  = 4'b0011;

  typedef enum logic [1:0] {
    SYS_ELR  = 2'b00,
    SYS_ESR  = 2'b01,
    SYS_CNT  = 2'b10,
    SYS_STAT = 2'b11
  } sys_sel_e;

  function automatic logic is_irq(input logic [3:0] estatus);
    return estatus == ESR_IRQ;
  endfunction

endpackage

// File: rtl/exception_ctrl_if.sv
// Decoder-facing bundle of the exception control stage (exception inputs,
// redirect/squash outputs, interrupt gating and MRS readout).
interface exception_ctrl_if #(parameter int N = 64);
  logic         ExtIRQ_i;
  logic         IRQ_o;
  logic         Exc_i;
  logic [3:0]   EStatus_i;
  logic         ERet_i;
  logic [N-1:0] PC_i;
  logic [1:0]   SysSel_i;
  logic         ExcRedirect_o;
  logic         ERetRedirect_o;
  logic [N-1:0] RedirectPC_o;
  logic         Squash_o;
  logic         ExcAck_o;
  logic         InHandler_o;
  logic         Fault_o;
  logic [N-1:0] SysReg_o;

  modport slave (
    input  ExtIRQ_i, Exc_i, EStatus_i, ERet_i, PC_i, SysSel_i,
    output IRQ_o, ExcRedirect_o, ERetRedirect_o, RedirectPC_o, Squash_o,
           ExcAck_o, InHandler_o, Fault_o, SysReg_o
  );

  modport master (
    output ExtIRQ_i, Exc_i, EStatus_i, ERet_i, PC_i, SysSel_i,
    input  IRQ_o, ExcRedirect_o, ERetRedirect_o, RedirectPC_o, Squash_o,
           ExcAck_o, InHandler_o, Fault_o, SysReg_o
  );
endinterface

// File: rtl/exc_sat_counter.sv
// Saturating up-counter of exceptions taken; holds at all-ones.
module exc_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/exception_ctrl.sv
// Exception control stage: latches ELR/ESR, redirects PC, masks ExtIRQ in handler.
// Optional exception counter enabled by defining EXC_COUNT_EN.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter int          N          = 64,
  parameter logic [63:0] EXC_VECTOR = 64'h0000_0000_0000_00D8,
  parameter int          CNT_W      = 16
) (
  input logic              clk,
  input logic              reset,
  exception_ctrl_if.slave  bus
);

  localparam logic [N-1:0] VEC = N'(EXC_VECTOR);

  exc_state_e   state_q, state_d;
  logic [N-1:0] elr_q, elr_d;
  logic [3:0]   esr_q, esr_d;
  logic         irq_pend_q, irq_pend_d;

  logic exc_redir, eret_redir, squash, ack, cnt_inc;
  logic [CNT_W-1:0] exc_cnt;

  always_comb begin
    state_d    = state_q;
    elr_d      = elr_q;
    esr_d      = esr_q;
    irq_pend_d = irq_pend_q;
    exc_redir  = 1'b0;
    eret_redir = 1'b0;
    squash     = 1'b0;
    ack        = 1'b0;
    cnt_inc    = 1'b0;

    if (bus.ExtIRQ_i && (state_q != RUN)) irq_pend_d = 1'b1;

    case (state_q)
      RUN: begin
        // A return with no handler active is itself an exception.
        if (bus.Exc_i || bus.ERet_i) begin
          exc_redir = 1'b1;
          squash    = 1'b1;
          cnt_inc   = 1'b1;
          elr_d     = bus.PC_i;
          esr_d     = bus.Exc_i ? bus.EStatus_i : ESR_BADERET;
          state_d   = HANDLER;
          if (bus.Exc_i && is_irq(bus.EStatus_i)) begin
            ack        = 1'b1;
            irq_pend_d = 1'b0;
          end
        end
      end
      HANDLER: begin
        if (bus.Exc_i) begin
          exc_redir = 1'b1;
          squash    = 1'b1;
          state_d   = FAULT;
        end else if (bus.ERet_i) begin
          eret_redir = 1'b1;
          state_d    = RUN;
        end
      end
      FAULT: begin
        exc_redir = 1'b1;
        squash    = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RUN;
      elr_q      <= '0;
      esr_q      <= '0;
      irq_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      elr_q      <= elr_d;
      esr_q      <= esr_d;
      irq_pend_q <= irq_pend_d;
    end
  end

`ifdef EXC_COUNT_EN
  exc_sat_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (cnt_inc),
    .cnt_o (exc_cnt)
  );
`else
  assign exc_cnt = '0;
`endif

  assign bus.IRQ_o          = (bus.ExtIRQ_i | irq_pend_q) & (state_q == RUN);
  assign bus.ExcRedirect_o  = exc_redir;
  assign bus.ERetRedirect_o = eret_redir;
  assign bus.RedirectPC_o   = eret_redir ? elr_q : VEC;
  assign bus.Squash_o       = squash;
  assign bus.ExcAck_o       = ack;
  assign bus.InHandler_o    = (state_q == HANDLER);
  assign bus.Fault_o        = (state_q == FAULT);

  always_comb begin
    bus.SysReg_o = '0;
    case (sys_sel_e'(bus.SysSel_i))
      SYS_ELR:  bus.SysReg_o = elr_q;
      SYS_ESR:  bus.SysReg_o = N'(esr_q);
      SYS_CNT:  bus.SysReg_o = N'(exc_cnt);
      SYS_STAT: bus.SysReg_o = N'({(state_q == FAULT), (state_q == HANDLER)});
      default:  bus.SysReg_o = '0;
    endcase
  end

endmodule
